blit_scheduler: RTL and testbench

//  Sequences the per-frame sprite-to-VRAM copy for the double-buffered drawing path.
//  At each frame start it latches the set of layer requesters (BG, holes, ball, overlays).
//  It copies each requester's 32x32 sprite into the back buffer in ascending index (painter's) order.

---
 rtl/blit_scheduler_if.sv | 31 +++
 rtl/blit_scheduler.sv | 148 ++++++++++++++
 tb/tb_blit_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_scheduler_if.sv
// Bus between the frame/layer logic and the sprite blit scheduler.
// The master side supplies the frame pulse and per-layer requests;
// the slave side (the scheduler) returns grants and the VRAM copy stream.
interface blit_scheduler_if #(
  parameter int NUM_REQ           = 4,
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITEBUF_A_WIDTH = 15
);
  logic                         frame_start;
  logic [NUM_REQ-1:0]           req;
  logic [10*NUM_REQ-1:0]        req_x;
  logic [10*NUM_REQ-1:0]        req_y;
  logic [4*NUM_REQ-1:0]         req_idx;
  logic [NUM_REQ-1:0]           grant;
  logic [SPRITEBUF_A_WIDTH-1:0] address_s;
  logic [VRAM_A_WIDTH-1:0]      address_screen;
  logic                         wr_valid;
  logic                         busy;
  logic                         frame_done;
  logic                         overrun;

  modport master (
    output frame_start, req, req_x, req_y, req_idx,
    input  grant, address_s, address_screen, wr_valid, busy, frame_done, overrun
  );

  modport slave (
    input  frame_start, req, req_x, req_y, req_idx,
    output grant, address_s, address_screen, wr_valid, busy, frame_done, overrun
  );
endinterface

// File: rtl/blit_scheduler.sv
// Per-frame sprite-to-VRAM copy sequencer. Latches the layer request mask at
// frame start, then copies each requested 32x32 sprite into the back buffer in
// ascending requester order. The screen write slot trails the sprite-ROM read
// address by one cycle so it lines up with the synchronous ROM data.
module blit_scheduler #(
  parameter int NUM_REQ           = 4,
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITEBUF_A_WIDTH = 15,
  parameter int SCREEN_WIDTH      = 320,
  parameter int SCREEN_HEIGHT     = 180,
  parameter int SPRITE_SIZE       = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  blit_scheduler_if.slave bus
);
  localparam int SW = $clog2(SPRITE_SIZE);
  localparam int KW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ARB, BLIT, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pending, pending_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [KW-1:0]      pick_k;
  logic [9:0]         x_sel, y_sel;
  logic [3:0]         idx_sel;
  logic [9:0]         cur_x, cur_y;
  logic [3:0]         cur_idx;
  logic [SW-1:0]      sx, sy, sx_nxt, sy_nxt;
  logic               last_px;
  logic [10:0]        px_p0, py_p0;

  function automatic logic [NUM_REQ-1:0] lowest_bit(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

  function automatic logic [KW-1:0] onehot_index(input logic [NUM_REQ-1:0] oh);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) k = KW'(i);
    return k;
  endfunction

  function automatic logic in_screen(input logic [10:0] px, input logic [10:0] py);
    return (32'(px) < 32'(SCREEN_WIDTH)) && (32'(py) < 32'(SCREEN_HEIGHT));
  endfunction

  function automatic logic [VRAM_A_WIDTH-1:0] screen_addr(input logic [10:0] px,
                                                          input logic [10:0] py);
    return VRAM_A_WIDTH'(32'(py) * 32'(SCREEN_WIDTH) + 32'(px));
  endfunction

  function automatic logic [SPRITEBUF_A_WIDTH-1:0] sprite_addr(input logic [3:0]    idx,
                                                               input logic [SW-1:0] y,
                                                               input logic [SW-1:0] x);
    return SPRITEBUF_A_WIDTH'(32'(idx) * 32'(SPRITE_SIZE * SPRITE_SIZE)
                              + 32'(y) * 32'(SPRITE_SIZE) + 32'(x));
  endfunction

  // Winner selection, sprite walk counters and current pixel position.
  always_comb begin
    pick    = lowest_bit(pending);
    pick_k  = onehot_index(pick);
    x_sel   = bus.req_x[10*int'(pick_k) +: 10];
    y_sel   = bus.req_y[10*int'(pick_k) +: 10];
    idx_sel = bus.req_idx[4*int'(pick_k) +: 4];
    sx_nxt  = sx + SW'(1);
    sy_nxt  = (&sx) ? sy + SW'(1) : sy;
    last_px = (&sx) && (&sy);
    px_p0   = 11'(cur_x) + 11'(sx);
    py_p0   = 11'(cur_y) + 11'(sy);
  end

  // Next-state logic; a frame pulse always restarts the walk from a fresh mask.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    if (bus.frame_start) begin
      state_nxt   = ARB;
      pending_nxt = bus.req;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        ARB: begin
          if (pending == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt   = BLIT;
            pending_nxt = pending & ~pick;
          end
        end
        BLIT:  if (last_px) state_nxt = DRAIN;
        DRAIN: state_nxt = (pending == '0) ? DONE : ARB;
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state and registered outputs; grant/busy/done are looked ahead
  // from the next state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      pending            <= '0;
      bus.grant          <= '0;
      bus.address_s      <= '0;
      bus.address_screen <= '0;
      bus.wr_valid       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.frame_done     <= 1'b0;
      bus.overrun        <= 1'b0;
    end else begin
      state          <= state_nxt;
      pending        <= pending_nxt;
      bus.grant      <= (state_nxt == ARB) ? lowest_bit(pending_nxt) : '0;
      bus.busy       <= (state_nxt != IDLE);
      bus.frame_done <= (state_nxt == DONE);
      if (bus.frame_start && (state != IDLE))
        bus.overrun <= 1'b1;
      // write slot for the pixel whose ROM address is on the bus this cycle
      bus.wr_valid       <= (state == BLIT) && !bus.frame_start && in_screen(px_p0, py_p0);
      bus.address_screen <= (state == BLIT) ? screen_addr(px_p0, py_p0) : '0;
      if ((state == ARB) && (state_nxt == BLIT))
        bus.address_s <= sprite_addr(idx_sel, '0, '0);
      else if ((state == BLIT) && (state_nxt == BLIT))
        bus.address_s <= sprite_addr(cur_idx, sy_nxt, sx_nxt);
      else
        bus.address_s <= '0;
    end
  end

  // Sprite parameters captured in ARB and the in-sprite pixel counters.
  always_ff @(posedge CLK) begin
    if ((state == ARB) && (state_nxt == BLIT)) begin
      cur_x   <= x_sel;
      cur_y   <= y_sel;
      cur_idx <= idx_sel;
      sx      <= '0;
      sy      <= '0;
    end else if (state == BLIT) begin
      sx <= sx_nxt;
      sy <= sy_nxt;
    end
  end
endmodule

// File: tb/tb_blit_scheduler.sv
// Testbench for blit_scheduler: table of frame scenarios with expected
// summary figures, per-cycle comparison against a timing model derived from
// the frame schedule, hand sequences for abort and async reset, random frames.
module tb_blit_scheduler;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  blit_scheduler_if bus ();
  blit_scheduler dut (.CLK(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]       mask;
    logic [3:0][9:0]  x;
    logic [3:0][9:0]  y;
    logic [3:0][3:0]  idx;
  } cfg_t;

  typedef struct {
    logic [3:0] g;
    logic       busy, done, vld, achk;
    int         addr_s, scr;
  } exp_t;

  typedef struct {
    int done_c, valid_cnt, first_scr, last_scr, addr_c2, addr_c1028, busy_cnt;
    logic [3:0] g1, g1027;
  } stats_t;

  typedef struct {
    cfg_t cfg;
    int exp_done, exp_valid, exp_first, exp_last, exp_busy;
    logic chk_a2;    int exp_a2;
    logic chk_a1028; int exp_a1028;
    logic [3:0] exp_g1, exp_g1027;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ovr  = 1'b0;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame schedule: requester m (in ascending order) owns cycles 1+m*1026 ..
  // 1+m*1026+1025: grant at offset 0, ROM reads at 1..1024, write slots 2..1025.
  function automatic exp_t model(input cfg_t cfg, input int c);
    exp_t e;
    int order[$];
    int n, done_c, m, off, k, j, px, py;
    e.g = '0; e.busy = 0; e.done = 0; e.vld = 0; e.achk = 0; e.addr_s = 0; e.scr = 0;
    for (int i = 0; i < 4; i++) if (cfg.mask[i]) order.push_back(i);
    n      = order.size();
    done_c = (n == 0) ? 2 : 1 + n * 1026;
    e.busy = (c >= 1) && (c <= done_c);
    e.done = (c == done_c);
    m   = (c - 1) / 1026;
    off = (c - 1) % 1026;
    if (c >= 1 && m < n) begin
      k = order[m];
      if (off == 0) e.g = 4'(1 << k);
      if (off >= 1 && off <= 1024) begin
        e.achk   = 1;
        e.addr_s = int'(cfg.idx[k]) * 1024 + off - 1;
      end
      if (off >= 2) begin
        j     = off - 2;
        px    = int'(cfg.x[k]) + j % 32;
        py    = int'(cfg.y[k]) + j / 32;
        e.vld = (px < 320) && (py < 180);
        e.scr = py * 320 + px;
      end
    end
    return e;
  endfunction

  task automatic start_frame(input cfg_t cfg);
    bus.req = cfg.mask;
    for (int i = 0; i < 4; i++) begin
      bus.req_x[10*i +: 10] = cfg.x[i];
      bus.req_y[10*i +: 10] = cfg.y[i];
      bus.req_idx[4*i +: 4] = cfg.idx[i];
    end
    bus.frame_start = 1'b1;
  endtask

  // Runs cycles 1.. of a frame started in the previous cycle, comparing each
  // cycle with the model; stops early after sampling cycle stop_at (if > 0).
  task automatic check_frame(input cfg_t cfg, input int stop_at, input bit scramble,
                             input string tag, output stats_t st);
    exp_t e;
    bit   dead, ok;
    int   n, last_c;
    n      = $countones(cfg.mask);
    last_c = (n == 0) ? 5 : n * 1026 + 4;
    st.done_c = -1; st.valid_cnt = 0; st.first_scr = -1; st.last_scr = -1;
    st.addr_c2 = 0; st.addr_c1028 = 0; st.busy_cnt = 0; st.g1 = '0; st.g1027 = '0;
    dead = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      if (scramble) bus.req = 4'($urandom);
      e = model(cfg, c);
      if (bus.frame_done === 1'b1 && st.done_c < 0) st.done_c = c;
      if (bus.busy === 1'b1) st.busy_cnt++;
      if (bus.wr_valid === 1'b1) begin
        st.valid_cnt++;
        if (st.first_scr < 0) st.first_scr = int'(bus.address_screen);
        st.last_scr = int'(bus.address_screen);
      end
      if (c == 1)    st.g1 = bus.grant;
      if (c == 1027) st.g1027 = bus.grant;
      if (c == 2)    st.addr_c2 = int'(bus.address_s);
      if (c == 1028) st.addr_c1028 = int'(bus.address_s);
      if (!dead) begin
        ok = (bus.grant === e.g) && (bus.busy === e.busy) && (bus.frame_done === e.done)
             && (bus.wr_valid === e.vld) && (bus.overrun === exp_ovr)
             && (!e.achk || (32'(bus.address_s) === 32'(e.addr_s)))
             && (!e.vld || (32'(bus.address_screen) === 32'(e.scr)));
        n_checks++;
        if (!ok) begin
          n_fail++;
          dead = 1;
          $display("FAIL %s cycle %0d: got grant=%b busy=%b done=%b vld=%b ovr=%b as=%0d scr=%0d; required grant=%b busy=%b done=%b vld=%b ovr=%b as=%0d(chk %b) scr=%0d",
                   tag, c, bus.grant, bus.busy, bus.frame_done, bus.wr_valid, bus.overrun,
                   bus.address_s, bus.address_screen, e.g, e.busy, e.done, e.vld, exp_ovr,
                   e.addr_s, e.achk, e.scr);
        end
      end
      if (c == stop_at) break;
    end
  endtask

  task automatic idle_check(input int ncyc, input string tag);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      n_checks++;
      if (!(bus.grant === 4'b0 && bus.busy === 1'b0 && bus.frame_done === 1'b0
            && bus.wr_valid === 1'b0 && bus.overrun === exp_ovr)) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: got grant=%b busy=%b done=%b vld=%b ovr=%b, required all 0 ovr=%b",
                 tag, c, bus.grant, bus.busy, bus.frame_done, bus.wr_valid, bus.overrun, exp_ovr);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_int({tag, "_grant"}, int'(bus.grant), 0);
    check_int({tag, "_address_s"}, int'(bus.address_s), 0);
    check_int({tag, "_address_screen"}, int'(bus.address_screen), 0);
    check_int({tag, "_wr_valid"}, int'(bus.wr_valid), 0);
    check_int({tag, "_busy"}, int'(bus.busy), 0);
    check_int({tag, "_frame_done"}, int'(bus.frame_done), 0);
    check_int({tag, "_overrun"}, int'(bus.overrun), 0);
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.mask = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 2))
        0: begin c.x[i] = 10'($urandom_range(0, 288));   c.y[i] = 10'($urandom_range(0, 148));   end
        1: begin c.x[i] = 10'($urandom_range(280, 340)); c.y[i] = 10'($urandom_range(140, 200)); end
        default: begin c.x[i] = 10'($urandom); c.y[i] = 10'($urandom); end
      endcase
      c.idx[i] = 4'($urandom);
    end
    return c;
  endfunction

  vec_t   vecs[4];
  stats_t st;
  cfg_t   c;

  initial begin
    bus.frame_start = 1'b0;
    bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_idx = '0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check(3, "post_reset");

    c = '0; c.mask = 4'b0001; c.idx[0] = 4'd1; c.x[1] = 10'd77; c.y[2] = 10'd33; c.idx[3] = 4'd9;
    vecs[0] = '{cfg:c, exp_done:1027, exp_valid:1024, exp_first:0, exp_last:9951, exp_busy:1027,
                chk_a2:1, exp_a2:1024, chk_a1028:0, exp_a1028:0, exp_g1:4'b0001, exp_g1027:4'b0000};
    c = '0; c.mask = 4'b1010; c.idx[1] = 4'd2; c.x[1] = 10'd10; c.y[1] = 10'd20;
    c.idx[3] = 4'd5; c.x[3] = 10'd100; c.y[3] = 10'd50; c.idx[0] = 4'd7;
    vecs[1] = '{cfg:c, exp_done:2053, exp_valid:2048, exp_first:6410, exp_last:26051, exp_busy:2053,
                chk_a2:1, exp_a2:2048, chk_a1028:1, exp_a1028:5120, exp_g1:4'b0010, exp_g1027:4'b1000};
    c = '0; c.mask = 4'b0001; c.x[0] = 10'd300; c.y[0] = 10'd170; c.idx[0] = 4'd0;
    vecs[2] = '{cfg:c, exp_done:1027, exp_valid:200, exp_first:54700, exp_last:57599, exp_busy:1027,
                chk_a2:1, exp_a2:0, chk_a1028:0, exp_a1028:0, exp_g1:4'b0001, exp_g1027:4'b0000};
    c = '0; c.mask = 4'b0000; c.x[0] = 10'd5; c.y[1] = 10'd6; c.idx[2] = 4'd3;
    vecs[3] = '{cfg:c, exp_done:2, exp_valid:0, exp_first:-1, exp_last:-1, exp_busy:2,
                chk_a2:0, exp_a2:0, chk_a1028:0, exp_a1028:0, exp_g1:4'b0000, exp_g1027:4'b0000};

    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      start_frame(vecs[t].cfg);
      check_frame(vecs[t].cfg, 0, 0, $sformatf("vec%0d", t), st);
      check_int($sformatf("vec%0d_done_cycle", t), st.done_c, vecs[t].exp_done);
      check_int($sformatf("vec%0d_valid_count", t), st.valid_cnt, vecs[t].exp_valid);
      check_int($sformatf("vec%0d_first_screen", t), st.first_scr, vecs[t].exp_first);
      check_int($sformatf("vec%0d_last_screen", t), st.last_scr, vecs[t].exp_last);
      check_int($sformatf("vec%0d_busy_cycles", t), st.busy_cnt, vecs[t].exp_busy);
      check_int($sformatf("vec%0d_grant_c1", t), int'(st.g1), int'(vecs[t].exp_g1));
      check_int($sformatf("vec%0d_grant_c1027", t), int'(st.g1027), int'(vecs[t].exp_g1027));
      if (vecs[t].chk_a2)
        check_int($sformatf("vec%0d_addr_s_c2", t), st.addr_c2, vecs[t].exp_a2);
      if (vecs[t].chk_a1028)
        check_int($sformatf("vec%0d_addr_s_c1028", t), st.addr_c1028, vecs[t].exp_a1028);
    end

    // Frame pulse in the middle of a blit: abort, flag overrun, restart walk.
    c = '0; c.mask = 4'b0011; c.x[0] = 10'd5; c.y[0] = 10'd5; c.idx[0] = 4'd3;
    c.x[1] = 10'd40; c.y[1] = 10'd40; c.idx[1] = 4'd7;
    @(negedge clk);
    start_frame(c);
    check_frame(c, 500, 0, "abort_first", st);
    c = '0; c.mask = 4'b0110; c.x[1] = 10'd100; c.y[1] = 10'd100; c.idx[1] = 4'd9;
    c.x[2] = 10'd200; c.y[2] = 10'd120; c.idx[2] = 4'd11;
    start_frame(c);
    exp_ovr = 1'b1;
    check_frame(c, 0, 0, "abort_restart", st);
    check_int("abort_grant_c501", int'(st.g1), 2);
    check_int("abort_done_cycle", st.done_c, 2053);
    check_int("overrun_sticky", int'(bus.overrun), 1);

    // Asynchronous reset in the middle of a blit.
    c = '0; c.mask = 4'b1111; c.idx = {4'd1, 4'd2, 4'd3, 4'd4};
    @(negedge clk);
    start_frame(c);
    check_frame(c, 700, 0, "pre_reset", st);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ovr = 1'b0;
    idle_check(20, "after_reset");

    // Random frames; request mask is scrambled after the frame pulse.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      c = rand_cfg();
      start_frame(c);
      check_frame(c, 0, 1, $sformatf("rand%0d", r), st);
      check_int($sformatf("rand%0d_done_cycle", r), st.done_c,
                ($countones(c.mask) == 0) ? 2 : 1 + $countones(c.mask) * 1026);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
